// File: rtl/gpmc_ram_streamer_if.sv
// Bus bundle for gpmc_ram_streamer: command channel, RAM port B, output stream and status.
// The master modport is the streamer itself. The slave modport is the host/RAM/sink side.
interface gpmc_ram_streamer_if #(
  parameter int addr_width = 12,
  parameter int data_width = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [addr_width-1:0] cmd_base;
  logic [addr_width-1:0] cmd_len;
  logic [addr_width-1:0] ram_addr;
  logic                  ram_rd;
  logic [data_width-1:0] ram_q;
  logic [data_width-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic                  busy;
  logic                  done;

  modport master (
    input  cmd_valid, cmd_base, cmd_len, ram_q, m_ready,
    output cmd_ready, ram_addr, ram_rd, m_data, m_valid, m_last, busy, done
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_len, ram_q, m_ready,
    input  cmd_ready, ram_addr, ram_rd, m_data, m_valid, m_last, busy, done
  );
endinterface

// File: rtl/gpmc_ram_streamer.sv
// Reads a frame from RAM port B and presents it as a valid/ready stream; pulses done at the end.
// Defining GPMC_STREAMER_CSUM_EN appends a wrap-around sum beat that carries m_last.
module gpmc_ram_streamer #(
  parameter int addr_width = 12,
  parameter int data_width = 16
) (
  input logic                 sys_clk,
  input logic                 rst,
  gpmc_ram_streamer_if.master bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
`ifdef GPMC_STREAMER_CSUM_EN
    , SUM = 2'd3
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] ptr_q, rem_q;
  logic                  inflight_q;
  logic [data_width-1:0] mem_q [2];
  logic                  wr_idx_q, rd_idx_q;
  logic [1:0]            count_q;
  logic                  done_q, done_d;
  logic                  fifo_valid, fifo_pop, issue, final_beat, accept;
  logic [2:0]            occ;
`ifdef GPMC_STREAMER_CSUM_EN
  logic [data_width-1:0] sum_q;
`endif

  // Occupancy is taken after this cycle's pop so a continuously ready sink sees one beat per cycle.
  always_comb begin
    fifo_valid = count_q != 2'd0;
    fifo_pop   = fifo_valid && bus.m_ready;
    occ        = 3'(count_q) + 3'(inflight_q) - 3'(fifo_pop);
    accept     = state_q == IDLE && bus.cmd_valid;
    issue      = !rst && state_q == RUN && rem_q != '0 && occ < 3'd2;
    final_beat = state_q == DRAIN && count_q == 2'd1 && !inflight_q;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_len != '0) state_d = RUN;
          else                   done_d  = 1'b1;
        end
      end
      RUN: begin
        if (issue && rem_q == addr_width'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (final_beat && fifo_pop) begin
`ifdef GPMC_STREAMER_CSUM_EN
          state_d = SUM;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef GPMC_STREAMER_CSUM_EN
      SUM: begin
        if (bus.m_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      mem_q      <= '{default: '0};
      wr_idx_q   <= 1'b0;
      rd_idx_q   <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
`ifdef GPMC_STREAMER_CSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      inflight_q <= issue;
      if (accept) begin
        ptr_q <= bus.cmd_base;
        rem_q <= bus.cmd_len;
      end else if (issue) begin
        ptr_q <= ptr_q + addr_width'(1);
        rem_q <= rem_q - addr_width'(1);
      end
      if (inflight_q) begin
        mem_q[wr_idx_q] <= bus.ram_q;
        wr_idx_q        <= ~wr_idx_q;
      end
      if (fifo_pop) rd_idx_q <= ~rd_idx_q;
      count_q <= count_q + 2'(inflight_q) - 2'(fifo_pop);
`ifdef GPMC_STREAMER_CSUM_EN
      if (accept)          sum_q <= '0;
      else if (inflight_q) sum_q <= sum_q + bus.ram_q;
`endif
    end
  end

  assign bus.cmd_ready = !rst && state_q == IDLE;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
  assign bus.ram_rd    = issue;
  assign bus.ram_addr  = ptr_q;
`ifdef GPMC_STREAMER_CSUM_EN
  assign bus.m_valid   = fifo_valid || state_q == SUM;
  assign bus.m_data    = (state_q == SUM) ? sum_q : mem_q[rd_idx_q];
  assign bus.m_last    = state_q == SUM;
`else
  assign bus.m_valid   = fifo_valid;
  assign bus.m_data    = mem_q[rd_idx_q];
  assign bus.m_last    = final_beat;
`endif
endmodule

// File: tb/tb_gpmc_ram_streamer.sv
// Bench for gpmc_ram_streamer: RAM model, stream monitor and a frame-level reference model.
module tb_gpmc_ram_streamer;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpmc_ram_streamer_if #(.addr_width(AW), .data_width(DW)) bus ();
  gpmc_ram_streamer #(.addr_width(AW), .data_width(DW)) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) if (bus.ram_rd) bus.ram_q <= mem[bus.ram_addr];

  // m_ready: 0 = always 1, 1 = pattern 1,0,0,1, else random
  int rmode = 0;
  int rcnt  = 0;
  always @(posedge clk) begin
    #1;
    if (rmode == 0) bus.m_ready = 1'b1;
    else if (rmode == 1) begin
      bus.m_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
      rcnt++;
    end else bus.m_ready = 1'($urandom_range(0, 1));
  end

  logic [DW:0]   beat_q[$];
  int            beat_cyc_q[$];
  logic [AW-1:0] rd_addr_q[$];
  int            rd_cyc_q[$];
  int            done_cyc_q[$];
  logic [DW:0]   exp_q[$];
  int stab_viol, max_out, issued_tot, acc_tot, valid_cycles, out_now;
  logic stall_prev = 1'b0;
  logic [DW:0] prev_beat;

  always @(negedge clk) begin
    if (rst) stall_prev = 1'b0;
    else begin
      out_now = issued_tot + int'(bus.ram_rd) - acc_tot - int'(bus.m_valid && bus.m_ready);
      if (out_now > max_out) max_out = out_now;
      if (bus.ram_rd) begin
        rd_addr_q.push_back(bus.ram_addr);
        rd_cyc_q.push_back(cyc);
        issued_tot++;
      end
      if (stall_prev && (!bus.m_valid || {bus.m_last, bus.m_data} !== prev_beat)) stab_viol++;
      if (bus.m_valid) begin
        valid_cycles++;
        if (bus.m_ready) begin
          beat_q.push_back({bus.m_last, bus.m_data});
          beat_cyc_q.push_back(cyc);
          acc_tot++;
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      prev_beat  = {bus.m_last, bus.m_data};
      if (bus.done) done_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_mon;
    beat_q.delete(); beat_cyc_q.delete(); rd_addr_q.delete(); rd_cyc_q.delete();
    done_cyc_q.delete();
    stab_viol = 0; max_out = 0; issued_tot = 0; acc_tot = 0; valid_cycles = 0;
  endtask

  // Reference: the frame is mem[(base+i) mod 2^AW]; last flag on the final beat.
  function automatic void build_expected(input logic [AW-1:0] base, input int len);
    int s;
    logic [DW-1:0] w;
    s = 0;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      w = mem[(int'(base) + i) % DEPTH];
`ifdef GPMC_STREAMER_CSUM_EN
      exp_q.push_back({1'b0, w});
      s = (s + int'(w)) % 65536;
`else
      exp_q.push_back({i == len - 1, w});
`endif
    end
`ifdef GPMC_STREAMER_CSUM_EN
    if (len > 0) exp_q.push_back({1'b1, DW'(s)});
`endif
  endfunction

  task automatic run_frame(input logic [AW-1:0] base, input logic [AW-1:0] len, output int c);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_base = base; bus.cmd_len = len;
    c = cyc;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done_cyc_q.size() != 0) break;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready_in_rst: got %b expected 0", bus.cmd_ready); end
    @(posedge clk); #1 rst = 1'b0;
    clear_mon;
    @(negedge clk);
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    n_checks++; if (bus.ram_rd !== 1'b0) begin n_fail++; $display("FAIL reset_ram_rd: got %b expected 0", bus.ram_rd); end
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
    n_checks++; if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b expected 0", bus.m_last); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.ram_addr !== '0) begin n_fail++; $display("FAIL reset_ram_addr: got %h expected 0", bus.ram_addr); end
    n_checks++; if (bus.m_data !== '0) begin n_fail++; $display("FAIL reset_m_data: got %h expected 0", bus.m_data); end
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (rd_addr_q.size() !== 0) begin n_fail++; $display("FAIL idle_reads: got %0d expected 0", rd_addr_q.size()); end
  endtask

  task automatic test_basic;
    int c;
    mem[12'h010] = 16'h1111; mem[12'h011] = 16'h2222;
    mem[12'h012] = 16'h3333; mem[12'h013] = 16'h4444;
    rmode = 0;
    clear_mon;
    build_expected(12'h010, 4);
    run_frame(12'h010, 12'd4, c);
    n_checks++; if (rd_cyc_q.size() !== 4) begin n_fail++; $display("FAIL basic_reads: got %0d expected 4", rd_cyc_q.size()); end
    for (int i = 0; i < rd_cyc_q.size() && i < 4; i++) begin
      n_checks++; if (rd_cyc_q[i] !== c + 1 + i || rd_addr_q[i] !== 12'h010 + AW'(i))
        begin n_fail++; $display("FAIL basic_read[%0d]: got cyc %0d addr %h expected cyc %0d addr %h", i, rd_cyc_q[i], rd_addr_q[i], c + 1 + i, 12'h010 + AW'(i)); end
    end
    n_checks++; if (beat_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL basic_beats: got %0d expected %0d", beat_q.size(), exp_q.size()); end
    for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (beat_q[i] !== exp_q[i] || beat_cyc_q[i] !== c + 3 + i)
        begin n_fail++; $display("FAIL basic_beat[%0d]: got %h at %0d expected %h at %0d", i, beat_q[i], beat_cyc_q[i], exp_q[i], c + 3 + i); end
    end
    n_checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== c + 3 + exp_q.size())
      begin n_fail++; $display("FAIL basic_done: got %0d pulses first at %0d expected 1 at %0d", done_cyc_q.size(), (done_cyc_q.size() != 0) ? done_cyc_q[0] : -1, c + 3 + exp_q.size()); end
  endtask

  task automatic test_wrap;
    int c;
    logic [AW-1:0] exp_addr [4];
    exp_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    rmode = 0;
    clear_mon;
    build_expected(12'hFFE, 4);
    run_frame(12'hFFE, 12'd4, c);
    n_checks++; if (rd_addr_q.size() !== 4) begin n_fail++; $display("FAIL wrap_reads: got %0d expected 4", rd_addr_q.size()); end
    for (int i = 0; i < rd_addr_q.size() && i < 4; i++) begin
      n_checks++; if (rd_addr_q[i] !== exp_addr[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, rd_addr_q[i], exp_addr[i]); end
    end
    n_checks++; if (beat_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL wrap_beats: got %0d expected %0d", beat_q.size(), exp_q.size()); end
    for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (beat_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_beat[%0d]: got %h expected %h", i, beat_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure;
    int c;
    logic [AW-1:0] base;
    base = AW'($urandom);
    rmode = 1; rcnt = 0;
    clear_mon;
    build_expected(base, 8);
    run_frame(base, 12'd8, c);
    n_checks++; if (beat_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_beats: got %0d expected %0d", beat_q.size(), exp_q.size()); end
    for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (beat_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_beat[%0d]: got %h expected %h", i, beat_q[i], exp_q[i]); end
    end
    n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", stab_viol); end
    n_checks++; if (max_out > 2) begin n_fail++; $display("FAIL bp_outstanding: got %0d expected <= 2", max_out); end
    n_checks++; if (rd_addr_q.size() !== 8) begin n_fail++; $display("FAIL bp_reads: got %0d expected 8", rd_addr_q.size()); end
    rmode = 0;
  endtask

  task automatic test_len_zero;
    int c;
    rmode = 0;
    clear_mon;
    run_frame(12'h123, 12'd0, c);
    n_checks++; if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== c + 1)
      begin n_fail++; $display("FAIL len0_done: got %0d pulses first at %0d expected 1 at %0d", done_cyc_q.size(), (done_cyc_q.size() != 0) ? done_cyc_q[0] : -1, c + 1); end
    n_checks++; if (valid_cycles !== 0) begin n_fail++; $display("FAIL len0_valid: got %0d valid cycles expected 0", valid_cycles); end
    n_checks++; if (rd_addr_q.size() !== 0) begin n_fail++; $display("FAIL len0_reads: got %0d expected 0", rd_addr_q.size()); end
  endtask

  task automatic test_busy_cmd;
    rmode = 0;
    clear_mon;
    build_expected(12'h200, 6);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_base = 12'h200; bus.cmd_len = 12'd6;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_base = 12'h300; bus.cmd_len = 12'd3;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0)
      begin n_fail++; $display("FAIL busy_flags: got busy %b cmd_ready %b expected 1 0", bus.busy, bus.cmd_ready); end
    repeat (2) @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done_cyc_q.size() != 0) break;
      @(posedge clk); #1;
    end
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (done_cyc_q.size() !== 1) begin n_fail++; $display("FAIL busy_done: got %0d pulses expected 1", done_cyc_q.size()); end
    n_checks++; if (rd_addr_q.size() !== 6) begin n_fail++; $display("FAIL busy_reads: got %0d expected 6", rd_addr_q.size()); end
    n_checks++; if (beat_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL busy_beats: got %0d expected %0d", beat_q.size(), exp_q.size()); end
    for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (beat_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_beat[%0d]: got %h expected %h", i, beat_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int c;
    int lasts;
    logic [AW-1:0] base;
    base = AW'($urandom);
    rmode = 0;
    clear_mon;
    build_expected(base, 10);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_base = base; bus.cmd_len = 12'd10;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_valid: got %b expected 0", bus.m_valid); end
    lasts = 0;
    foreach (beat_q[i]) if (beat_q[i][DW]) lasts++;
    n_checks++; if (lasts !== 0) begin n_fail++; $display("FAIL rstmid_last: got %0d last beats expected 0", lasts); end
    n_checks++; if (beat_q.size() !== 2) begin n_fail++; $display("FAIL rstmid_beats: got %0d expected 2", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 2; i++) begin
      n_checks++; if (beat_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_beat[%0d]: got %h expected %h", i, beat_q[i], exp_q[i]); end
    end
    repeat (2) @(posedge clk);
    #1;
    clear_mon;
    base = AW'($urandom);
    build_expected(base, 5);
    run_frame(base, 12'd5, c);
    n_checks++; if (beat_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rstmid_new_beats: got %0d expected %0d", beat_q.size(), exp_q.size()); end
    for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (beat_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_new_beat[%0d]: got %h expected %h", i, beat_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random;
    int c;
    int len;
    logic [AW-1:0] base;
    for (int f = 0; f < 6; f++) begin
      rmode = $urandom_range(0, 2);
      base  = AW'($urandom);
      len   = $urandom_range(1, 24);
      clear_mon;
      build_expected(base, len);
      run_frame(base, AW'(len), c);
      n_checks++; if (beat_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand%0d_beats: got %0d expected %0d", f, beat_q.size(), exp_q.size()); end
      for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++) begin
        n_checks++; if (beat_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_beat[%0d]: got %h expected %h", f, i, beat_q[i], exp_q[i]); end
      end
      n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL rand%0d_stable: got %0d expected 0", f, stab_viol); end
      n_checks++; if (max_out > 2) begin n_fail++; $display("FAIL rand%0d_outstanding: got %0d expected <= 2", f, max_out); end
      n_checks++; if (done_cyc_q.size() !== 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d expected 1", f, done_cyc_q.size()); end
    end
    rmode = 0;
  endtask

`ifdef GPMC_STREAMER_CSUM_EN
  task automatic test_csum;
    int c;
    logic [DW:0] want [3];
    want = '{{1'b0, 16'hFFFF}, {1'b0, 16'h0002}, {1'b1, 16'h0001}};
    mem[12'h100] = 16'hFFFF; mem[12'h101] = 16'h0002;
    rmode = 0;
    clear_mon;
    run_frame(12'h100, 12'd2, c);
    n_checks++; if (beat_q.size() !== 3) begin n_fail++; $display("FAIL csum_beats: got %0d expected 3", beat_q.size()); end
    for (int i = 0; i < beat_q.size() && i < 3; i++) begin
      n_checks++; if (beat_q[i] !== want[i]) begin n_fail++; $display("FAIL csum_beat[%0d]: got %h expected %h", i, beat_q[i], want[i]); end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0; bus.m_ready = 1'b1;
    for (int a = 0; a < DEPTH; a++) mem[a] = DW'($urandom);
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_len_zero;
    test_busy_cmd;
    test_reset_mid;
    test_random;
`ifdef GPMC_STREAMER_CSUM_EN
    test_csum;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected end of test within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
